// File: rtl/fetch_seq_pkg.sv
// Shared types and default widths for the fetch sequencer and its loop controller.
package fetch_seq_pkg;
  localparam int PC_W_DEF   = 8;
  localparam int CNT_W_DEF  = 8;
  localparam int PERF_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STALL  = 2'd2,
    HALTED = 2'd3
  } seq_state_t;
endpackage

// File: rtl/fetch_sequencer_loop_ctrl.sv
// Zero-overhead loop registers: captures body start/end/count on loop setup,
// flags a hit at the last body instruction and counts down on each loop-back.
module loop_ctrl #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             set,
  input  logic             dec,
  input  logic [PC_W-1:0]  pc,
  input  logic [PC_W-1:0]  set_end,
  input  logic [CNT_W-1:0] set_cnt,
  output logic             hit,
  output logic [PC_W-1:0]  loop_start,
  output logic             loop_active
);
  logic [PC_W-1:0]  loop_start_r;
  logic [PC_W-1:0]  loop_end_r;
  logic [CNT_W-1:0] loop_cnt_r;

  // Count holds the loop-backs still owed, so N passes need N-1; N=0 behaves like N=1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loop_start_r <= '0;
      loop_end_r   <= '0;
      loop_cnt_r   <= '0;
    end else if (clr) begin
      loop_start_r <= '0;
      loop_end_r   <= '0;
      loop_cnt_r   <= '0;
    end else if (set) begin
      loop_start_r <= pc + 1'b1;
      loop_end_r   <= set_end;
      loop_cnt_r   <= (set_cnt == '0) ? '0 : set_cnt - 1'b1;
    end else if (dec) begin
      loop_cnt_r   <= loop_cnt_r - 1'b1;
    end
  end

  assign loop_active = (loop_cnt_r != '0);
  assign hit         = loop_active && (pc == loop_end_r);
  assign loop_start  = loop_start_r;
endmodule

// File: rtl/fetch_sequencer.sv
// Program-control sequencer driving fetch_unit start/redirect inputs, with one hardware loop.
// Define FETCH_SEQ_PERF_CNT_EN to build the saturating retired-instruction counter.
//
// state  | meaning
// IDLE   | out of reset, waiting for start
// RUN    | fetching, redirects and loop setup accepted
// STALL  | fetch held; halt ignored
// HALTED | program finished, done asserted until start
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int PERF_W = PERF_W_DEF
) (
  input  logic              f_clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PC_W-1:0]   start_addr,
  input  logic [PC_W-1:0]   pc_i,
  input  logic              stall,
  input  logic              halt,
  input  logic              br_taken,
  input  logic [PC_W-1:0]   br_target,
  input  logic              loop_set,
  input  logic [CNT_W-1:0]  loop_cnt,
  input  logic [PC_W-1:0]   loop_end,
  output logic              fu_start,
  output logic [PC_W-1:0]   fu_start_addr,
  output logic              fu_taken,
  output logic [PC_W-1:0]   fu_target,
  output logic              fetch_en,
  output logic              loop_active,
  output logic              done,
  output logic [PERF_W-1:0] instr_cnt
);
  seq_state_t      state_q, state_d;
  logic            done_q;
  logic            run_fetch;
  logic            redir_ok;
  logic            hit;
  logic [PC_W-1:0] loop_start;

  always_ff @(posedge f_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == HALTED);
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = RUN;
    end else begin
      unique case (state_q)
        IDLE:    state_d = IDLE;
        RUN:     if (stall) state_d = STALL;
                 else if (halt) state_d = HALTED;
        STALL:   if (!stall) state_d = RUN;
        HALTED:  state_d = HALTED;
        default: state_d = IDLE;
      endcase
    end
  end

  assign run_fetch = (state_q == RUN) && !stall && !halt;
  assign redir_ok  = run_fetch && !start;

  // Combinational outputs are forced low while reset is held so the whole port goes quiet at once.
  assign fu_start      = start && !reset;
  assign fu_start_addr = reset ? '0 : start_addr;
  assign fetch_en      = !reset && (start || run_fetch);
  assign done          = done_q;

  always_comb begin
    fu_taken  = 1'b0;
    fu_target = '0;
    if (!reset && redir_ok) begin
      if (br_taken) begin
        fu_taken  = 1'b1;
        fu_target = br_target;
      end else if (hit) begin
        fu_taken  = 1'b1;
        fu_target = loop_start;
      end
    end
  end

  loop_ctrl #(
    .PC_W  (PC_W),
    .CNT_W (CNT_W)
  ) u_loop_ctrl (
    .clk         (f_clk),
    .rst         (reset),
    .clr         (start),
    .set         (redir_ok && loop_set),
    .dec         (redir_ok && hit && !br_taken),
    .pc          (pc_i),
    .set_end     (loop_end),
    .set_cnt     (loop_cnt),
    .hit         (hit),
    .loop_start  (loop_start),
    .loop_active (loop_active)
  );

`ifdef FETCH_SEQ_PERF_CNT_EN
  logic [PERF_W-1:0] instr_cnt_q;

  always_ff @(posedge f_clk or posedge reset) begin
    if (reset) begin
      instr_cnt_q <= '0;
    end else if (start) begin
      instr_cnt_q <= '0;
    end else if (run_fetch && (instr_cnt_q != '1)) begin
      instr_cnt_q <= instr_cnt_q + 1'b1;
    end
  end

  assign instr_cnt = instr_cnt_q;
`else
  assign instr_cnt = '0;
`endif
endmodule
